reg_bank_unit: RTL

Parametrised bank of N general-purpose W-bit registers, each with independent clear, parallel load, increment and decrement controls, a shared load-data bus, a selectable read port, per-register zero flags and registered wrap (overflow) pulses. It is the successor to the single load/increment register: one instance holds the Basic Computer's register set (AR, PC, DR, AC, IR, TR, SC, …) and feeds the common-bus mux through its read port.

---
 rtl/reg_bank_unit.sv | 74 +++++++
 1 files changed

// File: rtl/reg_bank_unit.sv
// Bank of N W-bit registers with per-register clear/load/inc/dec, shared load data,
// a read-select port, combinational zero flags and registered wrap pulses.
module reg_bank_unit #(
    parameter int unsigned    W       = 16,
    parameter int unsigned    N       = 8,
    parameter int unsigned    SELW    = $clog2(N),
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    clr,
    input  logic [N-1:0]    ld,
    input  logic [N-1:0]    inc,
    input  logic [N-1:0]    dec,
    input  logic [W-1:0]    data,
    input  logic [SELW-1:0] rd_sel,
    output logic [N*W-1:0]  q,
    output logic [W-1:0]    rd_data,
    output logic [N-1:0]    zero,
    output logic [N-1:0]    wrap
);

    logic [W-1:0] regs     [N];
    logic [W-1:0] nxt      [N];
    logic [N-1:0] wrap_nxt;

    // Per-register next value: clr > ld > inc > dec > hold
    always_comb begin
        wrap_nxt = '0;
        for (int i = 0; i < N; i++) begin
            nxt[i] = regs[i];
            if (clr[i]) begin
                nxt[i] = '0;
            end else if (ld[i]) begin
                nxt[i] = data;
            end else if (inc[i]) begin
                nxt[i]      = regs[i] + W'(1);
                wrap_nxt[i] = (regs[i] == {W{1'b1}});
            end else if (dec[i]) begin
                nxt[i]      = regs[i] - W'(1);
                wrap_nxt[i] = (regs[i] == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                regs[i] <= RST_VAL;
            end
            wrap <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                regs[i] <= nxt[i];
            end
            wrap <= wrap_nxt;
        end
    end

    // Packed view, zero flags and read mux; out-of-range select reads 0
    always_comb begin
        q       = '0;
        zero    = '0;
        rd_data = '0;
        for (int i = 0; i < N; i++) begin
            q[i*W +: W] = regs[i];
            zero[i]     = (regs[i] == '0);
            if (rd_sel == SELW'(i)) begin
                rd_data = regs[i];
            end
        end
    end

endmodule
